// File: rtl/tthbif_cfg_rf.sv
// Byte-command register file: parses UART rx cmd/data bytes into HBIF lane tap selects and enables.
// Optional macro TTHBIF_CFG_WR_ACK_EN: writes answer with ACK 0x06 (or NAK 0x15) instead of silently.
module tthbif_cfg_rf #(
    parameter int unsigned NUM_LANES      = 1,
    parameter int unsigned TIMEOUT_CYCLES = 65535
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   en_i,
    input  logic                   rx_valid_i,
    input  logic [7:0]             rx_data_i,
    input  logic                   tx_ready_i,
    output logic                   tx_valid_o,
    output logic [7:0]             tx_data_o,
    output logic [2*NUM_LANES-1:0] rx_flop_tap_sel_o,
    output logic [2*NUM_LANES-1:0] rx_comb_tap_sel_o,
    output logic [2*NUM_LANES-1:0] tx_flop_tap_sel_o,
    output logic [2*NUM_LANES-1:0] tx_comb_tap_sel_o,
    output logic [NUM_LANES-1:0]   lane_en_o,
    output logic                   err_o
);
    localparam int unsigned CNT_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [7:0]  ID_VAL = 8'h48;
    localparam logic [7:0]  ACK    = 8'h06;
    localparam logic [7:0]  NAK    = 8'h15;
`ifdef TTHBIF_CFG_WR_ACK_EN
    localparam bit WR_RESP = 1'b1;
`else
    localparam bit WR_RESP = 1'b0;
`endif

    typedef enum logic [1:0] {ST_IDLE, ST_WDATA, ST_RESP} state_e;

    state_e                      state_q, state_d;
    logic [CNT_W-1:0]            cnt_q, cnt_d;
    logic [6:0]                  addr_q, addr_d;
    logic                        tx_valid_q, tx_valid_d;
    logic [7:0]                  tx_data_q, tx_data_d;
    logic [7:0]                  scratch_q, scratch_d;
    logic [2:0]                  status_q, status_d;
    logic                        err_q, err_d;
    logic [NUM_LANES-1:0]        lane_en_q, lane_en_d;
    logic [NUM_LANES-1:0][7:0]   lane_cfg_q, lane_cfg_d;

    logic [6:0]  dec_addr;
    logic        rd_ok, wr_ok, timeout;
    logic [7:0]  rd_data;
    logic [15:0] lane_en_wide, lane_en_wide_d;
    logic [2:0]  set_st, clr_st;

    assign timeout      = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
    assign lane_en_wide = 16'(lane_en_q);
    // Idle decodes the incoming command byte; WDATA decodes the latched write address.
    assign dec_addr     = (state_q == ST_IDLE) ? rx_data_i[6:0] : addr_q;

    always_comb begin : addr_decode
        rd_ok   = 1'b0;
        wr_ok   = 1'b0;
        rd_data = 8'h00;
        case (dec_addr)
            7'h00: begin rd_ok = 1'b1; rd_data = ID_VAL; end
            7'h01: begin rd_ok = 1'b1; rd_data = 8'(NUM_LANES); end
            7'h02: begin rd_ok = 1'b1; wr_ok = 1'b1; rd_data = lane_en_wide[7:0]; end
            7'h03: begin rd_ok = 1'b1; wr_ok = 1'b1; rd_data = lane_en_wide[15:8]; end
            7'h04: begin rd_ok = 1'b1; wr_ok = 1'b1; rd_data = scratch_q; end
            7'h05: begin rd_ok = 1'b1; wr_ok = 1'b1; rd_data = {5'b0, status_q}; end
            default: ;
        endcase
        for (int unsigned l = 0; l < NUM_LANES; l++) begin
            if (dec_addr == 7'(7'h10 + l)) begin
                rd_ok   = 1'b1;
                wr_ok   = 1'b1;
                rd_data = lane_cfg_q[l];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin : state_reg
        if (!rst_ni) state_q <= ST_IDLE;
        else         state_q <= state_d;
    end

    always_comb begin : next_state
        state_d = state_q;
        if (!en_i) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:  if (rx_valid_i) state_d = rx_data_i[7] ? ST_WDATA : ST_RESP;
                ST_WDATA: begin
                    if (rx_valid_i)   state_d = WR_RESP ? ST_RESP : ST_IDLE;
                    else if (timeout) state_d = ST_IDLE;
                end
                ST_RESP:  if (tx_ready_i && tx_valid_q) state_d = ST_IDLE;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin : outputs
        cnt_d          = cnt_q;
        addr_d         = addr_q;
        tx_data_d      = tx_data_q;
        scratch_d      = scratch_q;
        lane_en_wide_d = lane_en_wide;
        lane_cfg_d     = lane_cfg_q;
        set_st         = 3'b000;
        clr_st         = 3'b000;
        tx_valid_d     = (state_d == ST_RESP);
        if (en_i) begin
            case (state_q)
                ST_IDLE: if (rx_valid_i) begin
                    addr_d = rx_data_i[6:0];
                    cnt_d  = '0;
                    if (!rx_data_i[7]) begin
                        tx_data_d = rd_ok ? rd_data : NAK;
                        set_st[0] = !rd_ok;
                    end
                end
                ST_WDATA: begin
                    if (rx_valid_i) begin
                        set_st[0] = !wr_ok;
                        if (WR_RESP) tx_data_d = wr_ok ? ACK : NAK;
                        if (wr_ok) begin
                            case (addr_q)
                                7'h02:   lane_en_wide_d[7:0]  = rx_data_i;
                                7'h03:   lane_en_wide_d[15:8] = rx_data_i;
                                7'h04:   scratch_d            = rx_data_i;
                                7'h05:   clr_st               = rx_data_i[2:0];
                                default: ;
                            endcase
                            for (int unsigned l = 0; l < NUM_LANES; l++) begin
                                if (addr_q == 7'(7'h10 + l)) lane_cfg_d[l] = rx_data_i;
                            end
                        end
                    end else if (timeout) begin
                        set_st[1] = 1'b1;
                    end else if (cnt_q != '1) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_RESP: if (rx_valid_i) set_st[2] = 1'b1;
                default: ;
            endcase
        end
        // A fresh error event wins over a simultaneous clear.
        status_d  = (status_q & ~clr_st) | set_st;
        err_d     = |status_d;
        lane_en_d = lane_en_wide_d[NUM_LANES-1:0];
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin : regs
        if (!rst_ni) begin
            cnt_q      <= '0;
            addr_q     <= 7'h00;
            tx_valid_q <= 1'b0;
            tx_data_q  <= 8'h00;
            scratch_q  <= 8'h00;
            status_q   <= 3'b000;
            err_q      <= 1'b0;
            lane_en_q  <= '1;
            lane_cfg_q <= '1;
        end else begin
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            tx_valid_q <= tx_valid_d;
            tx_data_q  <= tx_data_d;
            scratch_q  <= scratch_d;
            status_q   <= status_d;
            err_q      <= err_d;
            lane_en_q  <= lane_en_d;
            lane_cfg_q <= lane_cfg_d;
        end
    end

    assign tx_valid_o = tx_valid_q;
    assign tx_data_o  = tx_data_q;
    assign err_o      = err_q;
    assign lane_en_o  = lane_en_q;

    for (genvar g = 0; g < int'(NUM_LANES); g++) begin : g_lane_out
        assign rx_flop_tap_sel_o[2*g +: 2] = lane_cfg_q[g][1:0];
        assign rx_comb_tap_sel_o[2*g +: 2] = lane_cfg_q[g][3:2];
        assign tx_flop_tap_sel_o[2*g +: 2] = lane_cfg_q[g][5:4];
        assign tx_comb_tap_sel_o[2*g +: 2] = lane_cfg_q[g][7:6];
    end

endmodule

// File: tb/tb_tthbif_cfg_rf.sv
// Randomized self-checking bench for tthbif_cfg_rf against a register-level transaction model.
// Honors TTHBIF_CFG_WR_ACK_EN for the expected write responses.
module tb_tthbif_cfg_rf;
    localparam int unsigned NL        = 4;
    localparam int unsigned TO        = 20;
    localparam logic [15:0] LANE_MASK = 16'((1 << NL) - 1);

    logic            clk;
    logic            rst_n;
    logic            en;
    logic            rx_valid;
    logic [7:0]      rx_data;
    logic            tx_ready;
    logic            tx_valid;
    logic [7:0]      tx_data;
    logic [2*NL-1:0] rxf, rxc, txf, txc;
    logic [NL-1:0]   lane_en;
    logic            err;

    int n_cmp = 0;
    int n_mis = 0;

    // Register-level model state.
    logic [7:0]  m_lane [NL];
    logic [15:0] m_lane_en;
    logic [7:0]  m_scratch;
    logic [2:0]  m_status;

    tthbif_cfg_rf #(.NUM_LANES(NL), .TIMEOUT_CYCLES(TO)) dut (
        .clk_i             (clk),
        .rst_ni            (rst_n),
        .en_i              (en),
        .rx_valid_i        (rx_valid),
        .rx_data_i         (rx_data),
        .tx_ready_i        (tx_ready),
        .tx_valid_o        (tx_valid),
        .tx_data_o         (tx_data),
        .rx_flop_tap_sel_o (rxf),
        .rx_comb_tap_sel_o (rxc),
        .tx_flop_tap_sel_o (txf),
        .tx_comb_tap_sel_o (txc),
        .lane_en_o         (lane_en),
        .err_o             (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic void m_reset();
        for (int l = 0; l < NL; l++) m_lane[l] = 8'hFF;
        m_lane_en = LANE_MASK;
        m_scratch = 8'h00;
        m_status  = 3'b000;
    endfunction

    function automatic bit m_rd(input logic [6:0] a, output logic [7:0] d);
        int unsigned ai = 32'(a);
        d = 8'h00;
        if (ai == 0)                        d = 8'h48;
        else if (ai == 1)                   d = 8'(NL);
        else if (ai == 2)                   d = m_lane_en[7:0];
        else if (ai == 3)                   d = m_lane_en[15:8];
        else if (ai == 4)                   d = m_scratch;
        else if (ai == 5)                   d = {5'b0, m_status};
        else if (ai >= 16 && ai < 16 + NL)  d = m_lane[ai-16];
        else return 1'b0;
        return 1'b1;
    endfunction

    function automatic bit m_wr(input logic [6:0] a, input logic [7:0] d);
        int unsigned ai = 32'(a);
        logic [7:0] tmp;
        bit ok = m_rd(a, tmp) && (ai > 1);
        if (!ok) begin
            m_status[0] = 1'b1;
            return 1'b0;
        end
        if (ai == 2)      m_lane_en = {m_lane_en[15:8], d} & LANE_MASK;
        else if (ai == 3) m_lane_en = {d, m_lane_en[7:0]} & LANE_MASK;
        else if (ai == 4) m_scratch = d;
        else if (ai == 5) m_status  = m_status & ~d[2:0];
        else              m_lane[ai-16] = d;
        return 1'b1;
    endfunction

    task automatic check_outputs(input string tag);
        logic [2*NL-1:0] e_rxf, e_rxc, e_txf, e_txc;
        for (int l = 0; l < NL; l++) begin
            e_rxf[2*l +: 2] = m_lane[l][1:0];
            e_rxc[2*l +: 2] = m_lane[l][3:2];
            e_txf[2*l +: 2] = m_lane[l][5:4];
            e_txc[2*l +: 2] = m_lane[l][7:6];
        end
        chk({tag, ":rx_flop"}, 32'(rxf), 32'(e_rxf));
        chk({tag, ":rx_comb"}, 32'(rxc), 32'(e_rxc));
        chk({tag, ":tx_flop"}, 32'(txf), 32'(e_txf));
        chk({tag, ":tx_comb"}, 32'(txc), 32'(e_txc));
        chk({tag, ":lane_en"}, 32'(lane_en), 32'(m_lane_en[NL-1:0]));
        chk({tag, ":err"}, 32'(err), 32'(|m_status));
    endtask

    // Called at a negedge; returns at the following negedge.
    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
    endtask

    task automatic get_resp(input string tag, input logic [7:0] exp);
        int w = $urandom_range(0, 3);
        chk({tag, ":tx_valid"}, 32'(tx_valid), 32'd1);
        chk({tag, ":tx_data"}, 32'(tx_data), 32'(exp));
        repeat (w) begin
            @(negedge clk);
            chk({tag, ":hold_valid"}, 32'(tx_valid), 32'd1);
            chk({tag, ":hold_data"}, 32'(tx_data), 32'(exp));
        end
        tx_ready = 1'b1;
        @(negedge clk);
        tx_ready = 1'b0;
        chk({tag, ":tx_done"}, 32'(tx_valid), 32'd0);
    endtask

    task automatic do_read(input string tag, input logic [6:0] a);
        logic [7:0] d;
        if (!m_rd(a, d)) begin
            d = 8'h15;
            m_status[0] = 1'b1;
        end
        send_byte({1'b0, a});
        get_resp(tag, d);
        chk({tag, ":err"}, 32'(err), 32'(|m_status));
    endtask

    task automatic do_write(input string tag, input logic [6:0] a, input logic [7:0] d, input int gap);
        bit ok;
        send_byte({1'b1, a});
        repeat (gap) @(negedge clk);
        send_byte(d);
        ok = m_wr(a, d);
`ifdef TTHBIF_CFG_WR_ACK_EN
        get_resp(tag, ok ? 8'h06 : 8'h15);
`else
        chk({tag, ":no_resp"}, 32'(tx_valid), 32'd0);
`endif
        check_outputs(tag);
    endtask

    initial begin
        rst_n    = 1'b0;
        en       = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        tx_ready = 1'b0;
        m_reset();
        repeat (2) @(negedge clk);
        chk("rst:tx_valid", 32'(tx_valid), 32'd0);
        chk("rst:tx_data", 32'(tx_data), 32'h00);
        rst_n = 1'b1;
        @(negedge clk);
        check_outputs("rst");
        chk("rst:rx_flop_const", 32'(rxf), 32'hFF);
        chk("rst:lane_en_const", 32'(lane_en), 32'hF);

        // Lane 1 config write then readback.
        do_write("wr_lane1", 7'h11, 8'h1B, 0);
        chk("lane1_rx_flop", 32'(rxf[3:2]), 32'd3);
        chk("lane1_tx_comb", 32'(txc[3:2]), 32'd0);
        do_read("rd_lane1", 7'h11);
        do_read("rd_id", 7'h00);
        do_read("rd_nlanes", 7'h01);

        // Lane beyond NUM_LANES and bad writes, then W1C clear.
        do_read("rd_bad_lane", 7'h14);
        chk("bad_lane_err", 32'(err), 32'd1);
        do_write("wr_ro_id", 7'h00, 8'h12, 1);
        do_write("clr_status", 7'h05, 8'h01, 0);
        chk("cleared_err", 32'(err), 32'd0);

        // Data byte on the last cycle before timeout still commits.
        do_write("wr_late", 7'h04, 8'hA5, TO - 1);

        // Timeout: no data byte after write command.
        do_write("scr_zero", 7'h04, 8'h00, 0);
        send_byte(8'h84);
        repeat (TO - 1) @(negedge clk);
        chk("to_before", 32'(err), 32'd0);
        @(negedge clk);
        m_status[1] = 1'b1;
        chk("to_err", 32'(err), 32'd1);
        chk("to_no_resp", 32'(tx_valid), 32'd0);
        do_read("to_scratch", 7'h04);
        do_read("to_status", 7'h05);
        do_write("to_clr", 7'h05, 8'h07, 0);

        // Overrun while a response is pending.
        send_byte(8'h00);
        chk("ovr:valid", 32'(tx_valid), 32'd1);
        send_byte(8'h80);
        m_status[2] = 1'b1;
        chk("ovr:data", 32'(tx_data), 32'h48);
        chk("ovr:valid2", 32'(tx_valid), 32'd1);
        chk("ovr:err", 32'(err), 32'd1);
        get_resp("ovr", 8'h48);
        do_read("ovr_status", 7'h05);
        do_write("ovr_clr", 7'h05, 8'h04, 0);

        // Disable mid-write: nothing written, bytes ignored while disabled.
        send_byte(8'h82);
        en = 1'b0;
        @(negedge clk);
        chk("dis:valid", 32'(tx_valid), 32'd0);
        send_byte(8'h00);
        send_byte(8'h05);
        check_outputs("dis");
        en = 1'b1;
        do_read("dis_rd_lane_en", 7'h02);

        // Disable while a response is pending drops it.
        send_byte(8'h00);
        chk("dis_resp:valid", 32'(tx_valid), 32'd1);
        en = 1'b0;
        @(negedge clk);
        chk("dis_resp:dropped", 32'(tx_valid), 32'd0);
        en = 1'b1;
        @(negedge clk);
        chk("dis_resp:idle", 32'(tx_valid), 32'd0);

        // Async reset in the middle of a write.
        do_write("pre_rst", 7'h12, 8'h00, 0);
        send_byte(8'h90);
        #2 rst_n = 1'b0;
        #1;
        m_reset();
        check_outputs("async_rst");
        chk("async_rst:valid", 32'(tx_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send_byte(8'h00);
        get_resp("post_rst_id", 8'h48);
        do_read("post_rst_lane0", 7'h10);

        // Randomized traffic.
        for (int i = 0; i < 200; i++) begin
            logic [6:0] a;
            logic [7:0] d;
            a = ($urandom_range(0, 7) == 0) ? 7'($urandom) : 7'($urandom_range(0, 7'h15));
            d = 8'($urandom);
            if ($urandom_range(0, 1) == 0) do_read("rnd_rd", a);
            else                           do_write("rnd_wr", a, d, $urandom_range(0, 4));
        end
        check_outputs("final");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
